dual_ram_param: RTL and testbench
=================================

Name: dual_ram_param

Overview:
- Parametrised true dual-port synchronous RAM; next generation of the team's 64x8 dual-port RAM.
- Two independent ports (A, B) on one clock, with:
  - per-port enables;
  - configurable read-during-write mode;
  - deterministic write-collision arbitration with an error flag;
  - optional output register stage and read-valid strobes.
- Used as a shared buffer between two masters in the memory subsystem.

Parameters:
- DATA_W, 8, data width in bits (1..64)
- ADDR_W, 6, address width in bits
- DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
- READ_MODE, 0, 0 = read-first (old data), 1 = write-first (new data), for same-address accesses in one cycle
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- COLL_PRIO, 0, winner on a same-address dual write: 0 = port A, 1 = port B

Ports:
- clk  in  1  rising-edge clock for both ports
- rst_n  in  1  asynchronous active-low reset
- a_en  in  1  port A access enable
- a_we  in  1  port A write (1) / read (0); ignored when a_en=0
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data
- a_rvalid  out  1  a_rdata valid strobe, one cycle per read
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid  same as port A, for port B
- coll_err  out  1  one-cycle pulse: same-address dual write occurred

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - a_rdata, b_rdata = 0; a_rvalid, b_rvalid = 0; coll_err = 0.
  - Pipeline stage (OUT_REG=1) cleared.
  - Memory array is not cleared.
  - Writes are suppressed while rst_n is low.
- Deassertion: a port may issue its first access on the first rising edge after rst_n goes high. In-flight reads at reset assertion are dropped; no rvalid is produced for them.
- Write (en=1, we=1): the array word at addr is updated at the rising edge. No rvalid; rdata holds its previous value.
- Read (en=1, we=0):
  - OUT_REG=0: rdata updated and rvalid=1 in the cycle after the request edge (latency 1).
  - OUT_REG=1: the same result appears one cycle later (latency 2).
  - Back-to-back reads give one result per cycle, in order.
- Idle (en=0): no array access. rvalid=0 on the corresponding output cycle; rdata holds.
- Out of range (addr >= DEPTH):
  - Writes are ignored.
  - Reads return 0 with rvalid=1.
  - No coll_err from such writes.
- Cross-port read/write, same address, same edge:
  - READ_MODE=0: the reader gets the pre-write word.
  - READ_MODE=1: the reader gets the written data (bypass).
- Dual write, same in-range address, same edge:
  - The word takes the data of the port selected by COLL_PRIO; the losing write is discarded.
  - coll_err=1 for exactly one cycle following that edge.
- Dual write to different addresses: both words are updated; no coll_err.
- Dual read of the same address: both ports return the same word; no error.
- Each port's rvalid/rdata depend only on its own request stream; the two ports never stall each other.
- Implementation: single array shared by two always blocks. All updates use nonblocking assignment, so that port ordering does not change results apart from the defined collision rule.

Test Plan:
- Reset: hold rst_n=0 with a_en=a_we=1, a_addr=5, a_wdata=0x3C; release; read addr 5 -> word is not 0x3C. Outputs are 0 during reset.
- Basic ports, OUT_REG=0: A writes 0xA5 to 3; next cycle B reads 3 -> b_rdata=0xA5, b_rvalid=1 exactly one cycle after the request. Repeat with OUT_REG=1 -> latency 2.
- Read-during-write: word 10 holds 0x11. A writes 0x22 to 10 while B reads 10 on the same edge:
  - READ_MODE=0 -> b_rdata=0x11;
  - READ_MODE=1 -> b_rdata=0x22.
  - Later read of 10 -> 0x22 in both modes.
- Collision: A writes 0x01 and B writes 0x02 to addr 7 on the same edge:
  - COLL_PRIO=0 -> word 7 = 0x01; COLL_PRIO=1 -> 0x02.
  - coll_err high exactly one cycle.
  - Different addresses (7, 8) -> both words written, coll_err stays 0.
- Streaming and reset mid-read: A reads addrs 0..15 back-to-back -> 16 consecutive rvalid pulses with correct data. Assert rst_n mid-stream -> a_rvalid=0 immediately; no stale results after release.
- Out of range (DEPTH=48, ADDR_W=6): write 0xFF to 50 -> no effect, no coll_err; read 50 -> rdata=0, rvalid=1.

Source files
------------

// File: rtl/dual_ram_param_if.sv
// Bus bundle for both ports of dual_ram_param: request fields, read returns
// and the shared collision flag.
interface dual_ram_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6
);
   logic              a_en;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [DATA_W-1:0] a_rdata;
   logic              a_rvalid;
   logic              b_en;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic [DATA_W-1:0] b_rdata;
   logic              b_rvalid;
   logic              coll_err;

   modport master (
      output a_en, a_we, a_addr, a_wdata,
      output b_en, b_we, b_addr, b_wdata,
      input  a_rdata, a_rvalid, b_rdata, b_rvalid, coll_err
   );

   modport slave (
      input  a_en, a_we, a_addr, a_wdata,
      input  b_en, b_we, b_addr, b_wdata,
      output a_rdata, a_rvalid, b_rdata, b_rvalid, coll_err
   );
endinterface

// File: rtl/dual_ram_param.sv
// True dual-port synchronous RAM on one clock: per-port read/write, selectable
// read-during-write behaviour, prioritised write collisions, optional output register.
module dual_ram_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 6,
   parameter int DEPTH     = 64,
   parameter int READ_MODE = 0,
   parameter int OUT_REG   = 0,
   parameter int COLL_PRIO = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   dual_ram_param_if.slave  bus
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              a_in_rng, b_in_rng;
   logic              a_wr, b_wr, a_rd, b_rd;
   logic              same_addr, coll;
   logic              a_wr_win, b_wr_win;
   logic [IDX_W-1:0]  a_idx, b_idx;
   logic [DATA_W-1:0] a_word, b_word;

   logic [DATA_W-1:0] a_rdata_p1_q, a_rdata_p1_d, b_rdata_p1_q, b_rdata_p1_d;
   logic              a_vld_p1_q, a_vld_p1_d, b_vld_p1_q, b_vld_p1_d;
   logic              coll_err_q, coll_err_d;

   // Out-of-range reads yield zero; bypass forwards the other port's write data.
   function automatic logic [DATA_W-1:0] sel_word(
      input logic              in_rng,
      input logic              bypass,
      input logic [DATA_W-1:0] other_wdata,
      input logic [DATA_W-1:0] arr_word
   );
      if (!in_rng)     return '0;
      else if (bypass) return other_wdata;
      else             return arr_word;
   endfunction

   // Stage p0: decode requests, arbitrate collisions, pick the read word
   always_comb begin
      a_in_rng  = {1'b0, bus.a_addr} < DEPTH_C;
      b_in_rng  = {1'b0, bus.b_addr} < DEPTH_C;
      a_idx     = bus.a_addr[IDX_W-1:0];
      b_idx     = bus.b_addr[IDX_W-1:0];
      a_wr      = bus.a_en & bus.a_we & a_in_rng;
      b_wr      = bus.b_en & bus.b_we & b_in_rng;
      a_rd      = bus.a_en & ~bus.a_we;
      b_rd      = bus.b_en & ~bus.b_we;
      same_addr = (bus.a_addr == bus.b_addr);
      coll      = a_wr & b_wr & same_addr;
      a_wr_win  = a_wr & ~(coll & (COLL_PRIO != 0));
      b_wr_win  = b_wr & ~(coll & (COLL_PRIO == 0));

      a_word = sel_word(a_in_rng, (READ_MODE != 0) && b_wr_win && same_addr,
                        bus.b_wdata, a_in_rng ? mem_q[a_idx] : '0);
      b_word = sel_word(b_in_rng, (READ_MODE != 0) && a_wr_win && same_addr,
                        bus.a_wdata, b_in_rng ? mem_q[b_idx] : '0);

      a_vld_p1_d   = a_rd;
      b_vld_p1_d   = b_rd;
      a_rdata_p1_d = a_rd ? a_word : a_rdata_p1_q;
      b_rdata_p1_d = b_rd ? b_word : b_rdata_p1_q;
      coll_err_d   = coll;
   end

   // Losing collision write is already masked, so statement order is irrelevant.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (a_wr_win) mem_q[a_idx] <= bus.a_wdata;
         if (b_wr_win) mem_q[b_idx] <= bus.b_wdata;
      end
   end

   // Stage p1: array read result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rdata_p1_q <= '0;
         b_rdata_p1_q <= '0;
         a_vld_p1_q   <= 1'b0;
         b_vld_p1_q   <= 1'b0;
         coll_err_q   <= 1'b0;
      end else begin
         a_rdata_p1_q <= a_rdata_p1_d;
         b_rdata_p1_q <= b_rdata_p1_d;
         a_vld_p1_q   <= a_vld_p1_d;
         b_vld_p1_q   <= b_vld_p1_d;
         coll_err_q   <= coll_err_d;
      end
   end

   assign bus.coll_err = coll_err_q;

   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] a_rdata_p2_q, a_rdata_p2_d, b_rdata_p2_q, b_rdata_p2_d;
      logic              a_vld_p2_q, a_vld_p2_d, b_vld_p2_q, b_vld_p2_d;

      always_comb begin
         a_vld_p2_d   = a_vld_p1_q;
         b_vld_p2_d   = b_vld_p1_q;
         a_rdata_p2_d = a_vld_p1_q ? a_rdata_p1_q : a_rdata_p2_q;
         b_rdata_p2_d = b_vld_p1_q ? b_rdata_p1_q : b_rdata_p2_q;
      end

      // Stage p2: optional output register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_rdata_p2_q <= '0;
            b_rdata_p2_q <= '0;
            a_vld_p2_q   <= 1'b0;
            b_vld_p2_q   <= 1'b0;
         end else begin
            a_rdata_p2_q <= a_rdata_p2_d;
            b_rdata_p2_q <= b_rdata_p2_d;
            a_vld_p2_q   <= a_vld_p2_d;
            b_vld_p2_q   <= b_vld_p2_d;
         end
      end

      assign bus.a_rdata  = a_rdata_p2_q;
      assign bus.b_rdata  = b_rdata_p2_q;
      assign bus.a_rvalid = a_vld_p2_q;
      assign bus.b_rvalid = b_vld_p2_q;
   end else begin : g_noreg
      assign bus.a_rdata  = a_rdata_p1_q;
      assign bus.b_rdata  = b_rdata_p1_q;
      assign bus.a_rvalid = a_vld_p1_q;
      assign bus.b_rvalid = b_vld_p1_q;
   end

endmodule

// File: tb/tb_dual_ram_param.sv
// Directed bench: u0 = defaults (read-first, latency 1, A wins, depth 64);
// u1 = write-first, latency 2, B wins, depth 48. Both see the same stimulus.
module tb_dual_ram_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_en, a_we, b_en, b_we;
   logic [5:0] a_addr, b_addr;
   logic [7:0] a_wdata, b_wdata;
   int         n_chk = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   dual_ram_param_if #(.DATA_W(8), .ADDR_W(6)) if0 ();
   dual_ram_param_if #(.DATA_W(8), .ADDR_W(6)) if1 ();

   assign if0.a_en = a_en;   assign if0.a_we = a_we;   assign if0.a_addr = a_addr;   assign if0.a_wdata = a_wdata;
   assign if0.b_en = b_en;   assign if0.b_we = b_we;   assign if0.b_addr = b_addr;   assign if0.b_wdata = b_wdata;
   assign if1.a_en = a_en;   assign if1.a_we = a_we;   assign if1.a_addr = a_addr;   assign if1.a_wdata = a_wdata;
   assign if1.b_en = b_en;   assign if1.b_we = b_we;   assign if1.b_addr = b_addr;   assign if1.b_wdata = b_wdata;

   dual_ram_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .READ_MODE(0), .OUT_REG(0), .COLL_PRIO(0))
      u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   dual_ram_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .READ_MODE(1), .OUT_REG(1), .COLL_PRIO(1))
      u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic en, input logic we, input logic [5:0] addr, input logic [7:0] d);
      a_en = en; a_we = we; a_addr = addr; a_wdata = d;
   endtask

   task automatic drive_b(input logic en, input logic we, input logic [5:0] addr, input logic [7:0] d);
      b_en = en; b_we = we; b_addr = addr; b_wdata = d;
   endtask

   task automatic idle();
      drive_a(1'b0, 1'b0, 6'd0, 8'h00);
      drive_b(1'b0, 1'b0, 6'd0, 8'h00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      idle();
      drive_a(1'b1, 1'b1, 6'd5, 8'h3C);
      repeat (3) step();
      chk("rst_a_rdata0", if0.a_rdata, 8'h00);
      chk("rst_a_rvalid0", if0.a_rvalid, 1'b0);
      chk("rst_coll0", if0.coll_err, 1'b0);
      chk("rst_a_rdata1", if1.a_rdata, 8'h00);
      chk("rst_b_rvalid1", if1.b_rvalid, 1'b0);
      chk("rst_coll1", if1.coll_err, 1'b0);

      // Release, then read the word that was targeted during reset
      rst_n = 1'b1;
      drive_a(1'b1, 1'b0, 6'd5, 8'h00);
      step(); idle();
      chk("rst_nowr0", if0.a_rdata == 8'h3C, 1'b0);
      chk("rst_rv0", if0.a_rvalid, 1'b1);
      chk("rst_rv1_early", if1.a_rvalid, 1'b0);
      step();
      chk("rst_nowr1", if1.a_rdata == 8'h3C, 1'b0);
      chk("rst_rv1", if1.a_rvalid, 1'b1);

      // Basic write on A, read on B
      drive_a(1'b1, 1'b1, 6'd3, 8'hA5);
      step(); idle();
      chk("wr_norv0", if0.a_rvalid, 1'b0);
      drive_b(1'b1, 1'b0, 6'd3, 8'h00);
      step(); idle();
      chk("basic_rd0", if0.b_rdata, 8'hA5);
      chk("basic_rv0", if0.b_rvalid, 1'b1);
      chk("basic_rv1_early", if1.b_rvalid, 1'b0);
      step();
      chk("basic_rd1", if1.b_rdata, 8'hA5);
      chk("basic_rv1", if1.b_rvalid, 1'b1);
      chk("basic_rv0_once", if0.b_rvalid, 1'b0);

      // Read during write, same address
      drive_a(1'b1, 1'b1, 6'd10, 8'h11);
      step();
      drive_a(1'b1, 1'b1, 6'd10, 8'h22);
      drive_b(1'b1, 1'b0, 6'd10, 8'h00);
      step(); idle();
      chk("rdw_old0", if0.b_rdata, 8'h11);
      step();
      chk("rdw_new1", if1.b_rdata, 8'h22);
      drive_b(1'b1, 1'b0, 6'd10, 8'h00);
      step(); idle();
      chk("rdw_after0", if0.b_rdata, 8'h22);
      step();
      chk("rdw_after1", if1.b_rdata, 8'h22);
      chk("rdw_after1_rv", if1.b_rvalid, 1'b1);

      // Same-address dual write
      drive_a(1'b1, 1'b1, 6'd7, 8'h01);
      drive_b(1'b1, 1'b1, 6'd7, 8'h02);
      step(); idle();
      chk("coll_hi0", if0.coll_err, 1'b1);
      chk("coll_hi1", if1.coll_err, 1'b1);
      step();
      chk("coll_lo0", if0.coll_err, 1'b0);
      chk("coll_lo1", if1.coll_err, 1'b0);
      drive_a(1'b1, 1'b0, 6'd7, 8'h00);
      step(); idle();
      chk("coll_win0", if0.a_rdata, 8'h01);
      step();
      chk("coll_win1", if1.a_rdata, 8'h02);

      // Dual write to different addresses
      drive_a(1'b1, 1'b1, 6'd7, 8'h33);
      drive_b(1'b1, 1'b1, 6'd8, 8'h44);
      step(); idle();
      chk("diff_coll0", if0.coll_err, 1'b0);
      chk("diff_coll1", if1.coll_err, 1'b0);
      drive_a(1'b1, 1'b0, 6'd7, 8'h00);
      drive_b(1'b1, 1'b0, 6'd8, 8'h00);
      step(); idle();
      chk("diff_a0", if0.a_rdata, 8'h33);
      chk("diff_b0", if0.b_rdata, 8'h44);
      step();
      chk("diff_a1", if1.a_rdata, 8'h33);
      chk("diff_b1", if1.b_rdata, 8'h44);

      // Stream: fill 0..15 via B, read back-to-back via A
      for (int i = 0; i < 16; i++) begin
         drive_b(1'b1, 1'b1, 6'(i), 8'(8'h40 + i));
         step();
      end
      idle();
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) drive_a(1'b1, 1'b0, 6'(i), 8'h00);
         else        idle();
         step();
         if (i < 16) begin
            chk($sformatf("stream_rv0_%0d", i), if0.a_rvalid, 1'b1);
            chk($sformatf("stream_rd0_%0d", i), if0.a_rdata, 8'(8'h40 + i));
         end else begin
            chk("stream_end_rv0", if0.a_rvalid, 1'b0);
         end
         if (i == 0) begin
            chk("stream_start_rv1", if1.a_rvalid, 1'b0);
         end else begin
            chk($sformatf("stream_rv1_%0d", i - 1), if1.a_rvalid, 1'b1);
            chk($sformatf("stream_rd1_%0d", i - 1), if1.a_rdata, 8'(8'h40 + i - 1));
         end
      end

      // Reset asserted mid-stream
      drive_a(1'b1, 1'b0, 6'd0, 8'h00); step();
      drive_a(1'b1, 1'b0, 6'd1, 8'h00); step();
      drive_a(1'b1, 1'b0, 6'd2, 8'h00); step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rv0", if0.a_rvalid, 1'b0);
      chk("mid_rst_rv1", if1.a_rvalid, 1'b0);
      chk("mid_rst_rd0", if0.a_rdata, 8'h00);
      chk("mid_rst_rd1", if1.a_rdata, 8'h00);
      step(); step();
      idle();
      rst_n = 1'b1;
      step();
      chk("post_rst_rv0_a", if0.a_rvalid, 1'b0);
      chk("post_rst_rv1_a", if1.a_rvalid, 1'b0);
      step();
      chk("post_rst_rv0_b", if0.a_rvalid, 1'b0);
      chk("post_rst_rv1_b", if1.a_rvalid, 1'b0);

      // Address 50: in range for u0, out of range for u1
      drive_a(1'b1, 1'b1, 6'd50, 8'hFF);
      drive_b(1'b1, 1'b1, 6'd50, 8'hEE);
      step(); idle();
      chk("oor_coll0", if0.coll_err, 1'b1);
      chk("oor_coll1", if1.coll_err, 1'b0);
      drive_a(1'b1, 1'b0, 6'd1, 8'h00);
      step();
      drive_a(1'b1, 1'b0, 6'd50, 8'h00);
      chk("oor_pre0", if0.a_rdata, 8'h41);
      step(); idle();
      chk("oor_rd0", if0.a_rdata, 8'hFF);
      chk("oor_pre1", if1.a_rdata, 8'h41);
      step();
      chk("oor_rd1", if1.a_rdata, 8'h00);
      chk("oor_rv1", if1.a_rvalid, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
